// File: rtl/mips_bus_arbiter.sv
// Round-robin Avalon-MM master shared by NUM_CH requesters: one transfer in flight,
// optional stall watchdog, optional byte swap between a big-endian core and a little-endian bus.
module mips_bus_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int BIG_ENDIAN = 1,
  parameter int MAX_WAIT   = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CH-1:0]               ch_req,
  input  logic [NUM_CH-1:0]               ch_we,
  input  logic [NUM_CH*ADDR_W-1:0]        ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]        ch_wdata,
  input  logic [NUM_CH*(DATA_W/8)-1:0]    ch_be,
  output logic [NUM_CH-1:0]               ch_ack,
  output logic [DATA_W-1:0]               ch_rdata,
  output logic                            ch_err,
  output logic                            busy,
  output logic [ADDR_W-1:0]               address,
  output logic                            write,
  output logic                            read,
  input  logic                            waitrequest,
  output logic [DATA_W-1:0]               writedata,
  output logic [(DATA_W/8)-1:0]           byteenable,
  input  logic [DATA_W-1:0]               readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(BE_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_e;

  state_e            state_q;
  logic [CH_W-1:0]   ptr_q;
  logic [CH_W-1:0]   gnt_q;
  logic              we_q;
  logic [CNT_W-1:0]  stall_q;

  logic              gnt_valid_d;
  logic [CH_W-1:0]   gnt_d;
  logic [CH_W-1:0]   ptr_d;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic              bus_tmo;

  // Core byte order <-> bus lane order; identity when the core is little-endian.
  function automatic logic [DATA_W-1:0] lane_order(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    if (BIG_ENDIAN != 0) begin
      for (int j = 0; j < BE_W; j++) begin
        r[j*8 +: 8] = d[(BE_W-1-j)*8 +: 8];
      end
    end
    return r;
  endfunction

  // NOTE: every signal driven here gets a default before any branch, so no latch can be inferred.
  always_comb begin
    int idx;
    idx         = 0;
    gnt_valid_d = 1'b0;
    gnt_d       = ptr_q;
    // Scan from the farthest channel back to the pointer so the nearest requester wins.
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      idx = int'(ptr_q) + off;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (ch_req[idx]) begin
        gnt_valid_d = 1'b1;
        gnt_d       = CH_W'(idx);
      end
    end
    ptr_d     = (int'(gnt_d) == NUM_CH - 1) ? '0 : gnt_d + CH_W'(1);
    sel_we    = ch_we[gnt_d];
    sel_addr  = ch_addr[gnt_d*ADDR_W +: ADDR_W];
    sel_wdata = ch_wdata[gnt_d*DATA_W +: DATA_W];
    sel_be    = ch_be[gnt_d*BE_W +: BE_W];
  end

  assign bus_tmo = waitrequest && (MAX_WAIT > 0) && (int'(stall_q) == MAX_WAIT - 1);

  // NOTE: state and outputs update with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      we_q       <= 1'b0;
      stall_q    <= '0;
      ch_ack     <= '0;
      ch_rdata   <= '0;
      ch_err     <= 1'b0;
      busy       <= 1'b0;
      address    <= '0;
      write      <= 1'b0;
      read       <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
    end else begin
      ch_ack <= '0;
      case (state_q)
        S_IDLE: begin
          if (gnt_valid_d) begin
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            we_q       <= sel_we;
            address    <= sel_addr & ADDR_MASK;
            writedata  <= lane_order(sel_wdata);
            byteenable <= sel_be;
            read       <= ~sel_we;
            write      <= sel_we;
            busy       <= 1'b1;
            stall_q    <= '0;
            state_q    <= S_BUS;
          end
        end
        S_BUS: begin
          if (!waitrequest || bus_tmo) begin
            read          <= 1'b0;
            write         <= 1'b0;
            byteenable    <= '0;
            ch_ack[gnt_q] <= 1'b1;
            ch_err        <= bus_tmo;
            ch_rdata      <= (bus_tmo || we_q) ? '0 : lane_order(readdata);
            state_q       <= S_RESP;
          end else begin
            stall_q <= stall_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          busy     <= 1'b0;
          ch_err   <= 1'b0;
          ch_rdata <= '0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Transaction-level check of mips_bus_arbiter: two instances (big-endian with watchdog,
// little-endian without) against a round-robin/stall reference model.
module tb_mips_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        sel;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  be;
  logic        waitrequest;
  logic [31:0] readdata;

  logic [1:0]  a_req, b_req;
  logic [1:0]  a_ack, b_ack;
  logic [31:0] a_rdata, b_rdata, a_address, b_address, a_writedata, b_writedata;
  logic        a_err, b_err, a_busy, b_busy, a_write, b_write, a_read, b_read;
  logic [3:0]  a_be, b_be;

  logic [1:0]  o_ack;
  logic [31:0] o_rdata, o_address, o_writedata;
  logic        o_err, o_busy, o_write, o_read;
  logic [3:0]  o_be;

  int n_checks = 0;
  int n_errors = 0;
  int ptr_m [2];
  int gw;

  assign a_req       = sel ? 2'b00 : req;
  assign b_req       = sel ? req : 2'b00;
  assign o_ack       = sel ? b_ack : a_ack;
  assign o_rdata     = sel ? b_rdata : a_rdata;
  assign o_err       = sel ? b_err : a_err;
  assign o_busy      = sel ? b_busy : a_busy;
  assign o_address   = sel ? b_address : a_address;
  assign o_write     = sel ? b_write : a_write;
  assign o_read      = sel ? b_read : a_read;
  assign o_writedata = sel ? b_writedata : a_writedata;
  assign o_be        = sel ? b_be : a_be;

  mips_bus_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .BIG_ENDIAN(1), .MAX_WAIT(4)) dut_a (
    .clk(clk), .reset(reset), .ch_req(a_req), .ch_we(we), .ch_addr(addr), .ch_wdata(wdata),
    .ch_be(be), .ch_ack(a_ack), .ch_rdata(a_rdata), .ch_err(a_err), .busy(a_busy),
    .address(a_address), .write(a_write), .read(a_read), .waitrequest(waitrequest),
    .writedata(a_writedata), .byteenable(a_be), .readdata(readdata)
  );

  mips_bus_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .BIG_ENDIAN(0), .MAX_WAIT(0)) dut_b (
    .clk(clk), .reset(reset), .ch_req(b_req), .ch_we(we), .ch_addr(addr), .ch_wdata(wdata),
    .ch_be(be), .ch_ack(b_ack), .ch_rdata(b_rdata), .ch_err(b_err), .busy(b_busy),
    .address(b_address), .write(b_write), .read(b_read), .waitrequest(waitrequest),
    .writedata(b_writedata), .byteenable(b_be), .readdata(readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    we    = 2'($urandom);
    addr  = {$urandom, $urandom};
    wdata = {$urandom, $urandom};
    be    = 8'($urandom);
  endtask

  // One complete transfer, entered and left at a negedge in an IDLE cycle.
  // s = stall cycles the slave applies, rd = final readdata, keep = channels that re-request.
  task automatic do_grant(input int s, input logic [31:0] rd, input logic [1:0] keep,
                          output int w);
    int          maxw, n, c;
    bit          big, tmo;
    logic        e_we;
    logic [31:0] e_addr, e_wd, e_rd;
    logic [3:0]  e_be;
    big  = (sel == 1'b0);
    maxw = sel ? 0 : 4;
    w    = -1;
    for (int off = 0; off < 2; off++) begin
      c = (ptr_m[sel] + off) % 2;
      if (w < 0 && req[c]) w = c;
    end
    if (w < 0) begin
      w = ptr_m[sel];
      req[w] = 1'b1;
    end
    ptr_m[sel] = (w + 1) % 2;
    e_we   = we[w];
    e_addr = addr[w*32 +: 32] & 32'hFFFF_FFFC;
    e_wd   = big ? bswap(wdata[w*32 +: 32]) : wdata[w*32 +: 32];
    e_be   = be[w*4 +: 4];
    tmo    = (maxw > 0) && (s >= maxw);
    n      = tmo ? maxw : s + 1;
    e_rd   = (tmo || e_we) ? 32'h0 : (big ? bswap(rd) : rd);
    waitrequest = 1'($urandom);
    readdata    = (s > 0) ? $urandom : rd;
    @(negedge clk);
    for (int k = 1; k <= n; k++) begin
      check("bus_read", o_read, !e_we);
      check("bus_write", o_write, e_we);
      check("bus_address", o_address, e_addr);
      check("bus_writedata", o_writedata, e_wd);
      check("bus_byteenable", o_be, e_be);
      check("bus_ack", o_ack, 2'b00);
      check("bus_busy", o_busy, 1'b1);
      waitrequest = (k <= s);
      readdata    = (k < s) ? $urandom : rd;
      scramble();
      @(negedge clk);
    end
    check("resp_ack", o_ack, 2'b01 << w);
    check("resp_rdata", o_rdata, e_rd);
    check("resp_err", o_err, tmo);
    check("resp_strobes", {o_read, o_write}, 2'b00);
    check("resp_byteenable", o_be, 4'h0);
    check("resp_busy", o_busy, 1'b1);
    req[w] = keep[w];
    @(negedge clk);
    check("idle_ack", o_ack, 2'b00);
    check("idle_busy", o_busy, 1'b0);
    check("idle_strobes", {o_read, o_write}, 2'b00);
  endtask

  initial begin
    sel = 1'b0; reset = 1'b1; req = 2'b00; we = 2'b00; addr = '0; wdata = '0; be = '0;
    waitrequest = 1'b0; readdata = 32'hDEAD_BEEF;
    ptr_m[0] = 0; ptr_m[1] = 0;
    repeat (2) @(negedge clk);
    check("rst_ack", a_ack, 2'b00);
    check("rst_rdata", a_rdata, 32'h0);
    check("rst_err", a_err, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_address", a_address, 32'h0);
    check("rst_strobes", {a_read, a_write}, 2'b00);
    check("rst_writedata", a_writedata, 32'h0);
    check("rst_byteenable", a_be, 4'h0);
    reset = 1'b0;
    @(negedge clk);

    // ch0 zero-wait read with byte swap
    req = 2'b01; we = 2'b00; addr[31:0] = 32'hBFC0_0000; be[3:0] = 4'hF;
    do_grant(0, 32'h7856_3412, 2'b00, gw);

    // ch1 unaligned write with three stall cycles
    req = 2'b10; we = 2'b10; addr[63:32] = 32'h0000_1003; wdata[63:32] = 32'hAABB_CCDD; be[7:4] = 4'hF;
    do_grant(3, 32'h0, 2'b00, gw);

    // both channels hammering: grants must alternate
    req = 2'b11;
    for (int i = 0; i < 8; i++) do_grant($urandom_range(0, 2), $urandom, 2'b11, gw);
    req = 2'b00;

    // waitrequest stuck high: watchdog fires after four stall cycles
    req = 2'b01; we = 2'b00;
    do_grant(12, $urandom, 2'b00, gw);
    waitrequest = 1'b0;

    // random traffic on the big-endian/watchdog instance
    for (int i = 0; i < 60; i++) begin
      scramble();
      req = req | 2'($urandom);
      if (req == 2'b00) req = 2'($urandom_range(1, 3));
      do_grant($urandom_range(0, 5), $urandom, 2'($urandom), gw);
    end
    req = 2'b00;
    @(negedge clk);

    // asynchronous reset between edges while a read is on the bus
    req = 2'b01; we = 2'b00; waitrequest = 1'b1;
    @(negedge clk);
    check("pre_rst_read", a_read, 1'b1);
    check("pre_rst_busy", a_busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_read", a_read, 1'b0);
    check("async_rst_write", a_write, 1'b0);
    check("async_rst_busy", a_busy, 1'b0);
    check("async_rst_ack", a_ack, 2'b00);
    ptr_m[0] = 0; ptr_m[1] = 0;
    req = 2'b11;
    @(negedge clk);
    check("in_rst_ack", a_ack, 2'b00);
    check("in_rst_busy", a_busy, 1'b0);
    reset = 1'b0; waitrequest = 1'b0;
    do_grant(0, $urandom, 2'b00, gw);
    do_grant(1, $urandom, 2'b00, gw);

    // little-endian instance without watchdog
    sel = 1'b1;
    req = 2'b01; we = 2'b01; addr[31:0] = 32'h0000_2002; wdata[31:0] = 32'h0055_0000; be[3:0] = 4'b0100;
    do_grant(1, 32'h0, 2'b00, gw);
    req = 2'b10; we = 2'b00;
    do_grant(9, 32'h1122_3344, 2'b00, gw);
    for (int i = 0; i < 20; i++) begin
      scramble();
      req = req | 2'($urandom);
      if (req == 2'b00) req = 2'($urandom_range(1, 3));
      do_grant($urandom_range(0, 6), $urandom, 2'($urandom), gw);
    end
    req = 2'b00;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
